// File: rtl/bist_ctrl_pkg.sv
// Shared definitions for the logic-BIST sequencer: state encoding and the
// default golden signature used when a product does not override it.
package bist_ctrl_pkg;

    // Sequencer states; encodings are fixed so debug dumps stay comparable
    // across datapath configurations.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Default golden signature for the 4-bit TPG / 8-bit MISR datapath;
    // each product supplies its characterised value at instantiation.
    localparam logic [7:0] GOLDEN_DEFAULT = 8'h00;

    // True in the states where a test is in flight.
    function automatic logic is_busy(state_t s);
        return (s == ST_SEED) || (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_COMPARE);
    endfunction

endpackage

// File: rtl/bist_cnt.sv
// Cycle counter shared by the RUN and DRAIN phases: synchronous clear has
// priority over enable, and term flags the cycle whose count equals last.
module bist_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             term
);

    logic [CNT_W-1:0] count;

    // Count enabled cycles; clear wins so the next phase always starts at 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign term = (count == last);

endmodule

// File: rtl/bist_ctrl.sv
// Logic-BIST sequencer: seeds the TPG LFSRs and the MISR, runs N_PATTERNS
// pattern cycles, drains PIPE_DEPTH cycles of datapath latency into the MISR,
// then latches the signature and compares it against GOLDEN.
module bist_ctrl
    import bist_ctrl_pkg::*;
#(
    parameter int               N_PATTERNS = 15,
    parameter int               PIPE_DEPTH = 1,
    parameter int               SIG_W      = 8,
    parameter logic [SIG_W-1:0] GOLDEN     = SIG_W'(GOLDEN_DEFAULT),
    parameter int               CNT_W      = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Abort,
    input  logic [SIG_W-1:0] Signature,
    output logic             Tpg_set,
    output logic             Tpg_run,
    output logic             Misr_set,
    output logic             Misr_en,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [SIG_W-1:0] Sig_q
);

    // The terminal compare must be reachable without the counter wrapping.
    if (N_PATTERNS < 1 || N_PATTERNS > (2 ** CNT_W) - 1) begin : g_bad_n_patterns
        $error("bist_ctrl: N_PATTERNS must be in 1..2**CNT_W-1");
    end
    if (PIPE_DEPTH < 0 || PIPE_DEPTH > (2 ** CNT_W) - 1) begin : g_bad_pipe_depth
        $error("bist_ctrl: PIPE_DEPTH must be in 0..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_term;
    logic [CNT_W-1:0] cnt_last;
    logic             pass_q;
    logic [SIG_W-1:0] sig_q;

    // RUN and DRAIN share one counter; it is held at zero everywhere else and
    // cleared on its terminal cycle so the following phase starts from zero.
    assign cnt_en   = (state == ST_RUN) || (state == ST_DRAIN);
    assign cnt_clr  = !cnt_en || cnt_term;
    assign cnt_last = (state == ST_DRAIN) ? DRAIN_LAST : RUN_LAST;

    bist_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last),
        .term (cnt_term)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs; Abort overrides everything.
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_next = state;
        Tpg_set    = 1'b0;
        Tpg_run    = 1'b0;
        Misr_set   = 1'b0;
        Misr_en    = 1'b0;
        Busy       = is_busy(state);
        Done       = 1'b0;

        unique case (state)
            ST_SEED: begin
                Tpg_set  = 1'b1;
                Misr_set = 1'b1;
            end
            ST_RUN: begin
                Tpg_run = 1'b1;
                Misr_en = 1'b1;
            end
            ST_DRAIN: Misr_en = 1'b1;
            ST_DONE:  Done    = 1'b1;
            default: ;
        endcase

        if (Abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: if (Start) state_next = ST_SEED;
                ST_SEED:          state_next = ST_RUN;
                ST_RUN:           if (cnt_term) state_next = (PIPE_DEPTH > 0) ? ST_DRAIN : ST_COMPARE;
                ST_DRAIN:         if (cnt_term) state_next = ST_COMPARE;
                ST_COMPARE:       state_next = ST_DONE;
                default:          state_next = ST_IDLE;
            endcase
        end
    end

    // Latch the signature and verdict on COMPARE -> DONE; the verdict clears on
    // any exit from DONE while the signature is kept for post-mortem reads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sig_q  <= '0;
            pass_q <= 1'b0;
        end else if (state == ST_COMPARE && state_next == ST_DONE) begin
            sig_q  <= Signature;
            pass_q <= (Signature == GOLDEN);
        end else if (state_next != ST_DONE) begin
            pass_q <= 1'b0;
        end
    end

    assign Pass  = pass_q;
    assign Sig_q = sig_q;

endmodule
